// File: rtl/window3x3_gen_if.sv
// Row-triple input stream and 3x3x3 window output stream of window3x3_gen.
// The slave side is the window generator; the master side feeds rows and drains windows.
interface window3x3_gen_if #(
  parameter int PIX_W     = 8,
  parameter int WIDTH_PIX = 418
);
  localparam int ROW_W = WIDTH_PIX * PIX_W;
  localparam int WIN_W = 9 * PIX_W;

  logic             row_valid;
  logic             row_ready;
  logic [ROW_W-1:0] R_row0, R_row1, R_row2;
  logic [ROW_W-1:0] G_row0, G_row1, G_row2;
  logic [ROW_W-1:0] B_row0, B_row1, B_row2;

  logic             win_valid;
  logic             win_ready;
  logic [WIN_W-1:0] win_R, win_G, win_B;
  logic [8:0]       win_col;
  logic [8:0]       win_row;
  logic             win_last;
  logic             frame_done;

  modport slave (
    input  row_valid, R_row0, R_row1, R_row2, G_row0, G_row1, G_row2,
           B_row0, B_row1, B_row2, win_ready,
    output row_ready, win_valid, win_R, win_G, win_B, win_col, win_row,
           win_last, frame_done
  );

  modport master (
    output row_valid, R_row0, R_row1, R_row2, G_row0, G_row1, G_row2,
           B_row0, B_row1, B_row2, win_ready,
    input  row_ready, win_valid, win_R, win_G, win_B, win_col, win_row,
           win_last, frame_done
  );
endinterface

// File: rtl/window3x3_gen.sv
// Captures one padded R/G/B row triple and streams every 3x3x3 window left to right,
// one per accepted handshake, tracking output column/row and flagging end of frame.
module window3x3_gen #(
  parameter int PIX_W     = 8,
  parameter int WIDTH_PIX = 418,
  parameter int OUT_ROWS  = 416
) (
  input  logic           clk,
  input  logic           rst_n,  // asynchronous, active-high despite the name
  input  logic           en,
  window3x3_gen_if.slave bus
);
  localparam int         ROW_W    = WIDTH_PIX * PIX_W;
  localparam int         WIN_W    = 9 * PIX_W;
  localparam logic [8:0] LAST_COL = 9'(WIDTH_PIX - 3);
  localparam logic [8:0] LAST_ROW = 9'(OUT_ROWS - 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e           state_q, state_d;
  logic [8:0]       col_q, col_d;
  logic [8:0]       row_idx_q, row_idx_d;
  logic             frame_done_q, frame_done_d;
  logic             capture;
  logic             streaming;
  logic             xfer;
  logic             last;
  logic [ROW_W-1:0] row_in [9];
  logic [ROW_W-1:0] rows_q [9];
  logic [ROW_W-1:0] rows_d [9];
  logic [WIN_W-1:0] win [3];

  // Storage order: channel-major (R, G, B), then row 0..2 within the channel.
  assign row_in = '{bus.R_row0, bus.R_row1, bus.R_row2,
                    bus.G_row0, bus.G_row1, bus.G_row2,
                    bus.B_row0, bus.B_row1, bus.B_row2};

  assign streaming = (state_q == STREAM);
  assign last      = streaming && (col_q == LAST_COL);
  assign xfer      = en && streaming && bus.win_ready;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    col_d        = col_q;
    row_idx_d    = row_idx_q;
    frame_done_d = 1'b0;
    capture      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && bus.row_valid) begin
          capture = 1'b1;
          col_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (last) begin
            state_d = IDLE;
            col_d   = '0;
            if (row_idx_q == LAST_ROW) begin
              row_idx_d    = '0;
              frame_done_d = 1'b1;
            end else begin
              row_idx_d = row_idx_q + 9'd1;
            end
          end else begin
            col_d = col_q + 9'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    if (capture) rows_d = row_in;
    else         rows_d = rows_q;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_idx_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_idx_q    <= row_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: the wide row storage carries no reset; window outputs are forced to zero
  // outside STREAM, so a triple discarded by reset can never reach the consumer.
  always_ff @(posedge clk) begin
    rows_q <= rows_d;
  end

  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      win[ch] = '0;
      for (int r = 0; r < 3; r++) begin
        for (int j = 0; j < 3; j++) begin
          win[ch][PIX_W*(3*r+j) +: PIX_W] = rows_q[3*ch+r][PIX_W*(int'(col_q)+j) +: PIX_W];
        end
      end
    end
  end

  assign bus.row_ready  = (state_q == IDLE);
  assign bus.win_valid  = streaming;
  assign bus.win_R      = streaming ? win[0] : '0;
  assign bus.win_G      = streaming ? win[1] : '0;
  assign bus.win_B      = streaming ? win[2] : '0;
  assign bus.win_col    = col_q;
  assign bus.win_row    = row_idx_q;
  assign bus.win_last   = last;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen: table of hand-computed windows plus stall, freeze,
// mid-row reset and full-frame sequences checked against a pixel-formula model.
module tb_window3x3_gen;
  localparam int PIX_W     = 8;
  localparam int WIDTH_PIX = 418;
  localparam int OUT_ROWS  = 4;  // short frame keeps the run small; rows stay full width
  localparam int ROW_W     = WIDTH_PIX * PIX_W;
  localparam int LAST_COL  = WIDTH_PIX - 3;
  localparam int GUARD     = 4000;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  int   checks  = 0;
  int   errors  = 0;
  int   exp_row = 0;

  typedef struct {
    int          col;
    logic [71:0] r_win;
    logic        last;
  } vec_t;
  vec_t tbl [5];

  window3x3_gen_if #(.PIX_W(PIX_W), .WIDTH_PIX(WIDTH_PIX)) bus ();

  window3x3_gen #(.PIX_W(PIX_W), .WIDTH_PIX(WIDTH_PIX), .OUT_ROWS(OUT_ROWS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Triple t, channel ch, row r, pixel k.
  function automatic logic [7:0] pix(input int t, input int ch, input int r, input int k);
    return 8'((k + 10*r + 50*ch + 7*t) % 256);
  endfunction

  function automatic logic [ROW_W-1:0] mk_row(input int t, input int ch, input int r);
    logic [ROW_W-1:0] v;
    for (int k = 0; k < WIDTH_PIX; k++) v[8*k +: 8] = pix(t, ch, r, k);
    return v;
  endfunction

  function automatic logic [71:0] model_win(input int t, input int ch, input int c);
    logic [71:0] w;
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 3; j++)
        w[8*(3*r+j) +: 8] = pix(t, ch, r, c + j);
    return w;
  endfunction

  task automatic load_rows(input int t);
    bus.R_row0 = mk_row(t, 0, 0); bus.R_row1 = mk_row(t, 0, 1); bus.R_row2 = mk_row(t, 0, 2);
    bus.G_row0 = mk_row(t, 1, 0); bus.G_row1 = mk_row(t, 1, 1); bus.G_row2 = mk_row(t, 1, 2);
    bus.B_row0 = mk_row(t, 2, 0); bus.B_row1 = mk_row(t, 2, 1); bus.B_row2 = mk_row(t, 2, 2);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_window(input int t, input int col);
    check("win_valid",       128'(bus.win_valid),  128'(1'b1));
    check("row_ready_busy",  128'(bus.row_ready),  128'(1'b0));
    check("win_col",         128'(bus.win_col),    128'(col));
    check("win_row",         128'(bus.win_row),    128'(exp_row));
    check("win_last",        128'(bus.win_last),   128'(col == LAST_COL));
    check("frame_done_busy", 128'(bus.frame_done), 128'(1'b0));
    check("win_R",           128'(bus.win_R),      128'(model_win(t, 0, col)));
    check("win_G",           128'(bus.win_G),      128'(model_win(t, 1, col)));
    check("win_B",           128'(bus.win_B),      128'(model_win(t, 2, col)));
  endtask

  task automatic check_idle(input string tag, input int row, input bit fd);
    check({tag, "_row_ready"},  128'(bus.row_ready),  128'(1'b1));
    check({tag, "_win_valid"},  128'(bus.win_valid),  128'(1'b0));
    check({tag, "_win_col"},    128'(bus.win_col),    128'(0));
    check({tag, "_win_row"},    128'(bus.win_row),    128'(row));
    check({tag, "_win_last"},   128'(bus.win_last),   128'(1'b0));
    check({tag, "_frame_done"}, 128'(bus.frame_done), 128'(fd));
    check({tag, "_win_R"},      128'(bus.win_R),      128'(0));
    check({tag, "_win_G"},      128'(bus.win_G),      128'(0));
    check({tag, "_win_B"},      128'(bus.win_B),      128'(0));
  endtask

  // Entered at a falling edge with the DUT idle; leaves it idle after the last window.
  task automatic do_triple(input int t, input bit rnd, input bit hold_valid);
    int col   = 0;
    int guard = 0;
    bit rdy;
    bit fd;
    load_rows(t);
    bus.row_valid = 1'b1;
    bus.win_ready = 1'b0;
    @(negedge clk);
    bus.row_valid = hold_valid;
    load_rows(t + 50);  // inputs change after capture; windows must not follow them
    while (col <= LAST_COL && guard < GUARD) begin
      check_window(t, col);
      if (t == 0) begin
        foreach (tbl[i]) begin
          if (tbl[i].col == col) begin
            check("tbl_win_R",    128'(bus.win_R),    128'(tbl[i].r_win));
            check("tbl_win_last", 128'(bus.win_last), 128'(tbl[i].last));
          end
        end
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.win_ready = rdy;
      @(negedge clk);
      guard++;
      if (rdy) col++;
    end
    bus.win_ready = 1'b0;
    bus.row_valid = 1'b0;
    if (guard >= GUARD) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: reached col %0d, expected %0d", col, LAST_COL + 1);
    end
    fd      = (exp_row == OUT_ROWS - 1);
    exp_row = fd ? 0 : exp_row + 1;
    check_idle("end", exp_row, fd);
  endtask

  // Freeze with en=0 at col 100, resume, then reset asynchronously at col 200.
  task automatic freeze_and_reset(input int t);
    int col = 0;
    load_rows(t);
    bus.row_valid = 1'b1;
    @(negedge clk);
    bus.row_valid = 1'b0;
    load_rows(t + 50);
    bus.win_ready = 1'b1;
    repeat (100) begin @(negedge clk); col++; end
    check_window(t, col);
    en = 1'b0;
    bus.row_valid = 1'b1;
    repeat (5) begin @(negedge clk); check_window(t, col); end
    en = 1'b1;
    bus.row_valid = 1'b0;
    repeat (100) begin @(negedge clk); col++; end
    check_window(t, col);
    rst_n = 1'b1;
    #1;
    check_idle("midreset", 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.win_ready = 1'b0;
    exp_row = 0;
    @(negedge clk);
    check_idle("after_reset", 0, 1'b0);
  endtask

  initial begin
    // Triple 0, R channel: element (r,j) = (c + j + 10r) mod 256, element 0 in the low byte.
    tbl[0] = '{0,   {8'd22,  8'd21,  8'd20,  8'd12,  8'd11,  8'd10,  8'd2,   8'd1,   8'd0},   1'b0};
    tbl[1] = '{1,   {8'd23,  8'd22,  8'd21,  8'd13,  8'd12,  8'd11,  8'd3,   8'd2,   8'd1},   1'b0};
    tbl[2] = '{250, {8'd16,  8'd15,  8'd14,  8'd6,   8'd5,   8'd4,   8'd252, 8'd251, 8'd250}, 1'b0};
    tbl[3] = '{253, {8'd19,  8'd18,  8'd17,  8'd9,   8'd8,   8'd7,   8'd255, 8'd254, 8'd253}, 1'b0};
    tbl[4] = '{415, {8'd181, 8'd180, 8'd179, 8'd171, 8'd170, 8'd169, 8'd161, 8'd160, 8'd159}, 1'b1};

    rst_n         = 1'b1;
    en            = 1'b1;
    bus.row_valid = 1'b0;
    bus.win_ready = 1'b0;
    load_rows(0);
    repeat (2) @(negedge clk);
    check_idle("reset", 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);

    // Disabled stage must ignore an offered triple.
    en            = 1'b0;
    bus.row_valid = 1'b1;
    @(negedge clk);
    check("en0_row_ready", 128'(bus.row_ready), 128'(1'b1));
    check("en0_win_valid", 128'(bus.win_valid), 128'(1'b0));
    en            = 1'b1;
    bus.row_valid = 1'b0;
    @(negedge clk);

    do_triple(0, 1'b0, 1'b0);  // full-rate stream, hand table checked
    do_triple(1, 1'b1, 1'b1);  // random stalls, row_valid held through STREAM
    freeze_and_reset(5);
    for (int t = 6; t < 6 + OUT_ROWS; t++) do_triple(t, 1'b0, 1'b0);  // whole frame
    do_triple(20, 1'b1, 1'b0);  // first row of the next frame
    @(negedge clk);
    check("final_frame_done", 128'(bus.frame_done), 128'(1'b0));
    check("final_win_row",    128'(bus.win_row),    128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
